// File: rtl/eight_mux_scan_ctrl.sv
// Scan sequencer for the eight_mux datapath: walks SEL over the enabled
// channels, lets the mux path settle, then accumulates each sample.
module eight_mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        CK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [7:0]  MASK,
    input  logic [7:0]  MUX_DATA,
    output logic [2:0]  SEL,
    output logic        BUSY,
    output logic        DONE,
    output logic [10:0] SUM,
    output logic [3:0]  CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
    // With no settle time a channel goes straight to its sample cycle.
    localparam state_t CH_ENTRY = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  wait_q, wait_d;
    logic [10:0] sum_q, sum_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rem;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest = 3'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rem     = mask_q & ~(8'd1 << sel_q);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    mask_d = MASK;
                    sum_d  = '0;
                    cnt_d  = '0;
                    if (MASK != 8'd0) begin
                        sel_d   = lowest(MASK);
                        wait_d  = SETTLE_LD;
                        state_d = CH_ENTRY;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                sum_d  = sum_q + {3'b000, MUX_DATA};
                cnt_d  = cnt_q + 4'd1;
                mask_d = rem;
                if (rem != 8'd0) begin
                    sel_d   = lowest(rem);
                    wait_d  = SETTLE_LD;
                    state_d = CH_ENTRY;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            wait_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SEL  = sel_q;
    assign SUM  = sum_q;
    assign CNT  = cnt_q;
    assign BUSY = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign DONE = (state_q == S_DONE);

endmodule
